// File: rtl/alu_mc.sv
// Multi-cycle ALU with status flags; sequential shift-add multiplier built only when ALU_MUL_EN is defined.
// Latency: one cycle for all non-MUL opcodes, WIDTH+1 cycles from acceptance to result for MUL.
// Backpressure: result and flags hold while out_valid & !out_ready; in_ready = idle | (done & out_ready).
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] immediate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             carry,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MUL_EN
    MUL  = 2'd2,
`endif
    DONE = 2'd1
  } state_t;

  state_t           state, state_n;
  logic             accept;
  logic             start_single;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] c_res;
  logic             c_carry, c_ovf, c_ill;

  // ADDI/SUBI take the immediate as second operand; they are the only users of opcode[3] here
  assign op2 = opcode[3] ? immediate : b;

`ifdef ALU_MUL_EN
  logic                 is_mul;
  logic                 mul_last;
  logic                 msign;
  logic [SW-1:0]        cnt;
  logic [WIDTH-1:0]     mplr, mag_a, mag_b;
  logic [2*WIDTH-1:0]   mcand, acc, acc_nxt, prod;

  assign is_mul       = (opcode == 4'b1100);
  assign start_single = accept && !is_mul;
  // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1) correctly
  assign mag_a        = a[WIDTH-1] ? -a : a;
  assign mag_b        = b[WIDTH-1] ? -b : b;
  assign acc_nxt      = acc + (mplr[0] ? mcand : '0);
  // Sign is applied to the final iteration's sum so the result registers on the last MUL cycle
  assign prod         = msign ? -acc_nxt : acc_nxt;
  assign mul_last     = &cnt;

  // Shift-add multiplier: latch magnitudes on accept, then one multiplier bit per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      msign <= 1'b0;
    end else if (accept && is_mul) begin
      mcand <= {{WIDTH{1'b0}}, mag_a};
      mplr  <= mag_b;
      acc   <= '0;
      cnt   <= '0;
      msign <= a[WIDTH-1] ^ b[WIDTH-1];
    end else if (state == MUL) begin
      acc   <= acc_nxt;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
    end
  end
`else
  assign start_single = accept;
`endif

  // Single-cycle datapath: result, carry/borrow, overflow and illegal-opcode detection
  always_comb begin
    c_res   = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    c_ill   = 1'b0;
    case (opcode)
      4'b0010, 4'b1010: begin
        {c_carry, c_res} = {1'b0, a} + {1'b0, op2};
        c_ovf = (a[WIDTH-1] == op2[WIDTH-1]) && (c_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0011, 4'b1011: begin
        c_res   = a - op2;
        c_carry = (a < op2);
        c_ovf   = (a[WIDTH-1] != op2[WIDTH-1]) && (c_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0100: c_res = a & b;
      4'b0101: c_res = a | b;
      4'b0110: c_res = a ^ b;
      4'b0111: c_res = a << b[SW-1:0];
      4'b1000: c_res = a >> b[SW-1:0];
      4'b1001: c_res = $unsigned($signed(a) >>> b[SW-1:0]);
      4'b1101: c_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: c_ill = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and handshake; in_ready passes out_ready through combinationally in DONE
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
    state_n   = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_n = DONE;
`ifdef ALU_MUL_EN
          if (is_mul) state_n = MUL;
`endif
        end else if ((state == DONE) && out_ready) begin
          state_n = IDLE;
        end
      end
`ifdef ALU_MUL_EN
      MUL: if (mul_last) state_n = DONE;
`endif
      default: state_n = IDLE;
    endcase
  end

  // Result and flag registers: loaded on single-cycle accept or at multiplier completion, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      carry    <= 1'b0;
      illegal  <= 1'b0;
    end else if (start_single) begin
      result   <= c_res;
      zero     <= (c_res == '0);
      negative <= c_res[WIDTH-1];
      overflow <= c_ovf;
      carry    <= c_carry;
      illegal  <= c_ill;
    end
`ifdef ALU_MUL_EN
    else if ((state == MUL) && mul_last) begin
      result   <= prod[WIDTH-1:0];
      zero     <= (prod[WIDTH-1:0] == '0);
      negative <= prod[WIDTH-1];
      overflow <= (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
      carry    <= 1'b0;
      illegal  <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc (WIDTH=16): directed vector table, handshake corner sequences, randomized ops.
// Latency: expected latency is carried per vector and measured in cycles from acceptance.
// Backpressure: stall sequence holds out_ready low and checks result stability and in_ready.
module tb_alu_mc;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  opcode;
  logic [15:0] a, b, immediate, result;
  logic        zero, negative, overflow, carry, illegal;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, imm, res;
    logic [4:0]  flg;   // {zero, negative, overflow, carry, illegal}
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_mc #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .negative(negative), .overflow(overflow), .carry(carry), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: straight integer arithmetic on the opcode rules
  function automatic vec_t model(input logic [3:0] op, input logic [15:0] a_i, b_i, imm_i);
    vec_t v;
    int ua, ub, sa, sb, s, sh;
    longint p;
    logic [15:0] r;
    logic ov, cy, il;
    v.op = op; v.a = a_i; v.b = b_i; v.imm = imm_i; v.lat = 1;
    r = '0; ov = 1'b0; cy = 1'b0; il = 1'b0;
    ua = int'(a_i);
    sa = int'($signed(a_i));
    ub = (op == 4'hA || op == 4'hB) ? int'(imm_i) : int'(b_i);
    sb = (op == 4'hA || op == 4'hB) ? int'($signed(imm_i)) : int'($signed(b_i));
    sh = int'(b_i[3:0]);
    case (op)
      4'h2, 4'hA: begin
        r = 16'(ua + ub); cy = (ua + ub) > 65535;
        s = sa + sb; ov = (s > 32767) || (s < -32768);
      end
      4'h3, 4'hB: begin
        r = 16'(ua - ub); cy = (ua < ub);
        s = sa - sb; ov = (s > 32767) || (s < -32768);
      end
      4'h4: r = a_i & b_i;
      4'h5: r = a_i | b_i;
      4'h6: r = a_i ^ b_i;
      4'h7: r = 16'(ua << sh);
      4'h8: r = 16'(ua >> sh);
      4'h9: r = 16'(sa >>> sh);
      4'hD: r = (sa < sb) ? 16'd1 : 16'd0;
`ifdef ALU_MUL_EN
      4'hC: begin
        p = longint'(sa) * longint'(sb);
        r = 16'(p); ov = (p > 32767) || (p < -32768); v.lat = 17;
      end
`endif
      default: il = 1'b1;
    endcase
    v.res = r;
    v.flg = {(r == 16'd0), r[15], ov, cy, il};
    return v;
  endfunction

  // Issue one op at a negedge, scramble inputs after acceptance, measure latency and check outputs
  task automatic do_op(input vec_t v, input string name);
    int lat;
    logic busy_rdy;
    in_valid = 1'b1; opcode = v.op; a = v.a; b = v.b; immediate = v.imm; out_ready = 1'b1;
    #1;
    chk({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; opcode = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    immediate = 16'($urandom);
    lat = 1;
    busy_rdy = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_rdy = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, v.lat);
    if (v.lat > 1) chk({name, "_busy_in_ready"}, busy_rdy, 0);
    chk({name, "_result"}, result, v.res);
    chk({name, "_flags"}, {zero, negative, overflow, carry, illegal}, v.flg);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; a = '0; b = '0; immediate = '0;

    // Directed vectors with hand-derived expectations
    vecs.push_back('{4'h2, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 5'b01100, 1});
    vecs.push_back('{4'hB, 16'h0005, 16'h1234, 16'h0005, 16'h0000, 5'b10000, 1});
    vecs.push_back('{4'h3, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE, 5'b01010, 1});
    vecs.push_back('{4'h6, 16'h00FF, 16'h0F0F, 16'h0000, 16'h0FF0, 5'b00000, 1});
    vecs.push_back('{4'h4, 16'h00FF, 16'h0F0F, 16'h0000, 16'h000F, 5'b00000, 1});
    vecs.push_back('{4'h5, 16'h00FF, 16'h0F0F, 16'h0000, 16'h0FFF, 5'b00000, 1});
    vecs.push_back('{4'h9, 16'h8000, 16'h0004, 16'h0000, 16'hF800, 5'b01000, 1});
    vecs.push_back('{4'h8, 16'h8000, 16'h0004, 16'h0000, 16'h0800, 5'b00000, 1});
    vecs.push_back('{4'h7, 16'h0001, 16'h000F, 16'h0000, 16'h8000, 5'b01000, 1});
    vecs.push_back('{4'h7, 16'h1234, 16'h0010, 16'h0000, 16'h1234, 5'b00000, 1});
    vecs.push_back('{4'hD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 5'b00000, 1});
    vecs.push_back('{4'hD, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 5'b10000, 1});
    vecs.push_back('{4'hA, 16'hFFFF, 16'h7777, 16'h0001, 16'h0000, 5'b10010, 1});
    vecs.push_back('{4'h2, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 5'b10110, 1});
    vecs.push_back('{4'hB, 16'h8000, 16'h0000, 16'h0001, 16'h7FFF, 5'b00100, 1});
    vecs.push_back('{4'h3, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 5'b01010, 1});
    vecs.push_back('{4'h0, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 5'b10001, 1});
    vecs.push_back('{4'hF, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 5'b10001, 1});
    vecs.push_back('{4'hE, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 5'b10001, 1});
`ifdef ALU_MUL_EN
    vecs.push_back('{4'hC, 16'hFFFD, 16'h0007, 16'h0000, 16'hFFEB, 5'b01000, 17});
    vecs.push_back('{4'hC, 16'h012C, 16'h012C, 16'h0000, 16'h5F90, 5'b00100, 17});
    vecs.push_back('{4'hC, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 5'b01100, 17});
    vecs.push_back('{4'hC, 16'h0000, 16'hFFFB, 16'h0000, 16'h0000, 5'b10000, 17});
`else
    vecs.push_back('{4'hC, 16'hFFFD, 16'h0007, 16'h0000, 16'h0000, 5'b10001, 1});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_result", result, 16'h0000);
    chk("reset_flags", {zero, negative, overflow, carry, illegal}, 5'b00000);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: XOR result held for 5 stalled cycles while an AND request waits
    in_valid = 1'b1; opcode = 4'h6; a = 16'h00FF; b = 16'h0F0F; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opcode = 4'h4; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_valid%0d", i), out_valid, 1);
      chk($sformatf("bp_result%0d", i), result, 16'h0FF0);
      chk($sformatf("bp_in_ready%0d", i), in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_and_valid", out_valid, 1);
    chk("bp_and_result", result, 16'h000F);
    @(negedge clk);

    // Reset in the middle of a long operation (or during a stalled result without the multiplier)
`ifdef ALU_MUL_EN
    in_valid = 1'b1; opcode = 4'hC; a = 16'hFFFD; b = 16'h0007; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
`else
    in_valid = 1'b1; opcode = 4'h6; a = 16'h00FF; b = 16'h0F0F; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
`endif
    rst = 1'b1;
    #1;
    chk("midrst_result", result, 16'h0000);
    chk("midrst_flags", {zero, negative, overflow, carry, illegal}, 5'b00000);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", out_valid, 0);
    do_op('{4'h9, 16'h8000, 16'h0004, 16'h0000, 16'hF800, 5'b01000, 1}, "postrst_sra");

    // Randomized ops against the reference model, issued back to back
    for (int i = 0; i < 150; i++) begin
      vec_t v;
      v = model(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom));
      do_op(v, $sformatf("rnd%0d_op%0h", i, v.op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
